alu_mc: RTL
===========

Name: alu_mc

Overview:
- Parametrised multi-cycle ALU. It is the next generation of the single-cycle `alu`.
- Operand width is generic. Input and output each use a valid/ready handshake.
- MUL, DIV and REM are iterative. Signed and unsigned division are both supported, with defined divide-by-zero and overflow results.
- Sits between the register-file read stage and writeback. Exactly one operation is in flight at a time.

Parameters:
- WIDTH, 64, operand and result width in bits. Legal values are 8 to 64, power of two.
- OPW, 8, width of the opcode input.
- CNTW, $clog2(WIDTH)+1, width of the internal iteration counter. Derived; not overridden.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- opcode  in  OPW  operation select (see Behaviour).
- value1  in  WIDTH  operand A.
- value2  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  operation result.
- out_illegal  out  1  the opcode was unsupported; qualified by out_valid.

Behaviour:
- Reset (reset low, takes effect immediately):
  - state goes to IDLE.
  - in_ready=1 once reset is deasserted; out_valid=0, result=0, out_illegal=0.
  - All internal registers clear. Any in-flight operation is discarded and never reported.
- Opcodes (unsigned decode of opcode):
  - 0 ADD, 1 SUB, 2 MUL (low WIDTH bits), 3 DIV (signed), 4 XOR, 5 AND, 6 OR, 7 REM (signed), 8 NOT (~value1), 9 DIVU, 10 REMU.
  - 11 SLL: value1 shifted left by value2[$clog2(WIDTH)-1:0].
  - 12 SRA: arithmetic right shift by the same amount.
  - Any other value: result=0, out_illegal=1.
- Arithmetic:
  - All arithmetic is modulo 2^WIDTH.
  - There is no gating on value2 (unlike the previous generation, which held its result when value2=0).
- Handshake:
  - A request is accepted on a rising edge with in_valid && in_ready.
  - Operands and opcode are captured at acceptance. Later input changes are ignored.
  - in_ready=1 only in IDLE.
  - A result is consumed on an edge with out_valid && out_ready.
  - out_valid, result and out_illegal stay stable until the result is consumed.
  - On consumption the state returns to IDLE. The next request can be accepted no earlier than the edge after consumption.
- State machine:
  - IDLE -> DONE on acceptance of a single-cycle op (0,1,4,5,6,8,11,12, illegal). Result is registered at that edge.
  - IDLE -> BUSY on acceptance of MUL/DIV/REM/DIVU/REMU.
    - Counter is loaded with WIDTH.
    - Signed ops latch the operand signs and take absolute values.
  - BUSY: one iteration per cycle, counter decrements.
    - MUL: radix-2 shift-add.
    - Division ops: restoring shift-subtract.
    - BUSY -> FIX on the edge where the counter reaches 0.
  - FIX: applies signs and special cases, registers the result, then -> DONE.
  - DONE -> IDLE on consumption.
- Latency (acceptance edge to out_valid high):
  - Single-cycle ops: 1 cycle.
  - Iterative ops: WIDTH+2 cycles.
- Division rules (RISC-V semantics, quotient truncated toward zero):
  - Remainder sign equals dividend sign.
  - Divisor = 0: quotient = all ones, remainder = value1, for both signed and unsigned.
  - Signed overflow (value1 = MIN, value2 = -1): quotient = MIN, remainder = 0.
- Simultaneous events:
  - in_valid while in BUSY/FIX/DONE has no effect; the request must be held by the source.
  - out_ready while out_valid=0 is ignored.
  - reset overrides everything.

Optional Feature:
- Macro: ALU_MC_EARLY_OUT_EN.
- Defined:
  - Iterative ops skip BUSY when value2 = 0 (DIV/REM/DIVU/REMU/MUL), or value1 = 0 for MUL.
  - Path is IDLE -> FIX -> DONE, giving a latency of 2 cycles, with results per the rules above (MUL gives 0).
- Undefined: every iterative op takes the full WIDTH+2 cycles.

Test Plan:
- WIDTH=8: reset low mid-BUSY of a DIV, then released -> out_valid=0, result=0, in_ready=1, no stale result ever appears.
- WIDTH=8: MUL 0x13 * 0x11 -> result 0x43 after 10 cycles. ADD 0xFF + 0x02 -> 0x01 after 1 cycle.
- WIDTH=8, signed division and overflow:
  - DIV 0xF9 / 0x02 -> 0xFD.
  - REM 0xF9 / 0x02 -> 0xFF.
  - DIV 0x80 / 0xFF -> 0x80.
  - REM 0x80 / 0xFF -> 0x00.
- WIDTH=8, divide by zero:
  - DIV 0x25 / 0 -> 0xFF.
  - REMU 0x25 / 0 -> 0x25.
  - Latency 10 without ALU_MC_EARLY_OUT_EN, 2 with it.
- WIDTH=64 backpressure:
  - DIVU 1000 / 7 with out_ready=0 for 5 cycles after out_valid -> result holds 142; in_ready stays 0.
  - Then out_ready=1 -> IDLE and a new request is accepted on the following edge.
- Opcode 13 -> out_illegal=1, result=0, latency 1. Opcode 11 with value1=1, value2=0x43 (WIDTH=64) -> result 0x8.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/shift ops, iterative MUL/DIV/REM with RISC-V division semantics.
// Define ALU_MC_EARLY_OUT_EN to let iterative ops with a zero operand bypass the iteration loop.
module alu_mc #(
  parameter int WIDTH = 64,
  parameter int OPW   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   opcode,
  input  logic [WIDTH-1:0] value1,
  input  logic [WIDTH-1:0] value2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_illegal
);

  localparam int CNTW = $clog2(WIDTH) + 1;
  localparam int SHW  = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_e;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3, OP_XOR = 4'd4,
    OP_AND = 4'd5, OP_OR = 4'd6, OP_REM = 4'd7, OP_NOT = 4'd8, OP_DIVU = 4'd9,
    OP_REMU = 4'd10, OP_SLL = 4'd11, OP_SRA = 4'd12
  } op_e;

  state_e           r_state;
  op_e              r_op;
  logic [CNTW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_q, r_result;
  logic             r_neg_a, r_neg_b, r_illegal, r_out_valid, r_in_ready;

  op_e              w_op;
  logic             w_legal, w_iter, w_signed, w_neg_a, w_neg_b, w_sub_ok;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_single;
  logic [WIDTH:0]   w_rem_sh, w_diff;

  assign w_op     = op_e'(opcode[3:0]);
  assign w_legal  = (opcode < OPW'(13));
  assign w_iter   = w_legal && (w_op == OP_MUL || w_op == OP_DIV || w_op == OP_REM ||
                                w_op == OP_DIVU || w_op == OP_REMU);
  assign w_signed = (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_neg_a  = w_signed & value1[WIDTH-1];
  assign w_neg_b  = w_signed & value2[WIDTH-1];
  assign w_abs_a  = w_neg_a ? -value1 : value1;
  assign w_abs_b  = w_neg_b ? -value2 : value2;

  // Restoring division: partial remainder in r_acc, dividend shifts out of r_q as quotient shifts in.
  assign w_rem_sh = {r_acc, r_q[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_b};
  assign w_sub_ok = ~w_diff[WIDTH];

  always_comb begin
    w_single = '0;
    case (w_op)
      OP_ADD:  w_single = value1 + value2;
      OP_SUB:  w_single = value1 - value2;
      OP_XOR:  w_single = value1 ^ value2;
      OP_AND:  w_single = value1 & value2;
      OP_OR:   w_single = value1 | value2;
      OP_NOT:  w_single = ~value1;
      OP_SLL:  w_single = value1 << value2[SHW-1:0];
      OP_SRA:  w_single = $unsigned($signed(value1) >>> value2[SHW-1:0]);
      default: w_single = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_op        <= OP_ADD;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_q         <= '0;
      r_result    <= '0;
      r_neg_a     <= 1'b0;
      r_neg_b     <= 1'b0;
      r_illegal   <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            if (!w_iter) begin
              r_result    <= w_legal ? w_single : '0;
              r_illegal   <= ~w_legal;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              // r_a keeps value1 intact for division so FIX can return it on divide-by-zero.
              r_op    <= w_op;
              r_a     <= value1;
              r_b     <= w_abs_b;
              r_q     <= w_abs_a;
              r_acc   <= '0;
              r_neg_a <= w_neg_a;
              r_neg_b <= w_neg_b;
              r_cnt   <= CNTW'(WIDTH);
`ifdef ALU_MC_EARLY_OUT_EN
              if (value2 == '0 || (w_op == OP_MUL && value1 == '0))
                r_state <= S_FIX;
              else
                r_state <= S_BUSY;
`else
              r_state <= S_BUSY;
`endif
            end
          end
        end
        S_BUSY: begin
          if (r_op == OP_MUL) begin
            if (r_b[0]) r_acc <= r_acc + r_a;
            r_a <= r_a << 1;
            r_b <= r_b >> 1;
          end else begin
            r_acc <= w_sub_ok ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], w_sub_ok};
          end
          r_cnt <= r_cnt - CNTW'(1);
          if (r_cnt == CNTW'(1)) r_state <= S_FIX;
        end
        S_FIX: begin
          case (r_op)
            OP_MUL:  r_result <= r_acc;
            OP_DIVU: r_result <= (r_b == '0) ? '1 : r_q;
            OP_REMU: r_result <= (r_b == '0) ? r_a : r_acc;
            OP_DIV:  r_result <= (r_b == '0) ? '1 : ((r_neg_a ^ r_neg_b) ? -r_q : r_q);
            OP_REM:  r_result <= (r_b == '0) ? r_a : (r_neg_a ? -r_acc : r_acc);
            default: r_result <= '0;
          endcase
          r_illegal   <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign out_illegal = r_illegal;

endmodule
